// File: rtl/uart_hex_line_formatter_pkg.sv
// Shared constants, FSM state type and line-length helper for the hex line formatter.
package uart_fmt_pkg;

  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] ZERO    = 8'h30;
  localparam logic [7:0] UPPER_A = 8'h41;

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    WAIT_HI,
    WAIT_LO,
    DONE
  } fmt_state_t;

  // Number of characters in one printed line, terminator included.
  function automatic int line_len(input int data_width, input int addr_en, input int crlf);
    return ((addr_en != 0) ? 3 : 0) + data_width / 4 + ((crlf != 0) ? 2 : 1);
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational conversion of one 4-bit value to its uppercase ASCII hex digit.
module hex_nibble_ascii
  import uart_fmt_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ZERO + {4'h0, nibble};
    else                ascii = UPPER_A + {4'h0, nibble} - 8'd10;
  end

endmodule

// File: rtl/uart_hex_line_formatter.sv
// Latches one register word/address and prints it as an "AA:DDDD\r\n" ASCII line,
// one byte per transmitter handshake (strobe, wait for busy rise, wait for busy fall).
module uart_hex_line_formatter
  import uart_fmt_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_EN      = 1,
  parameter int CRLF         = 1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [4:0]            i_addr,
  input  logic                  i_dv,
  output logic                  o_ready,
  output logic [7:0]            o_uart_data,
  output logic                  o_uart_dv,
  input  logic                  i_uart_busy,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam int L          = line_len(DATA_WIDTH, ADDR_EN, CRLF);
  localparam int NDIG       = DATA_WIDTH / 4;
  localparam int ADDR_CHARS = (ADDR_EN != 0) ? 3 : 0;
  localparam int IDX_W      = $clog2(L) + 1;
  localparam int TMO_W      = $clog2(BUSY_TIMEOUT) + 1;

  fmt_state_t            state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [TMO_W-1:0]      tmo_reg, tmo_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [7:0]            addr_reg;
  logic [7:0]            uart_data_reg;
  logic                  overflow_reg;
  logic                  accept;
  logic [7:0]            char_sel;
  logic [7:0]            addr_hi_ascii, addr_lo_ascii;
  logic [7:0]            data_ascii [NDIG];

  assign accept = i_dv && (state_reg == IDLE);

  hex_nibble_ascii u_addr_hi (.nibble(addr_reg[7:4]), .ascii(addr_hi_ascii));
  hex_nibble_ascii u_addr_lo (.nibble(addr_reg[3:0]), .ascii(addr_lo_ascii));

  // Digit 0 is the most significant nibble so the line reads naturally.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      hex_nibble_ascii u_nib (
        .nibble(data_reg[DATA_WIDTH-1-4*gi -: 4]),
        .ascii (data_ascii[gi])
      );
    end
  endgenerate

  always_comb begin
    char_sel = LF;
    if (ADDR_EN != 0) begin
      if      (idx_reg == IDX_W'(0)) char_sel = addr_hi_ascii;
      else if (idx_reg == IDX_W'(1)) char_sel = addr_lo_ascii;
      else if (idx_reg == IDX_W'(2)) char_sel = COLON;
    end
    for (int k = 0; k < NDIG; k++) begin
      if (idx_reg == IDX_W'(ADDR_CHARS + k)) char_sel = data_ascii[k];
    end
    if (CRLF != 0 && idx_reg == IDX_W'(ADDR_CHARS + NDIG)) char_sel = CR;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      tmo_reg       <= '0;
      data_reg      <= '0;
      addr_reg      <= '0;
      uart_data_reg <= 8'h00;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      tmo_reg   <= tmo_next;
      if (accept) begin
        data_reg <= i_data;
        addr_reg <= {3'b000, i_addr};
      end
      if (i_dv && !accept) overflow_reg <= 1'b1;
      // Keep the last strobed byte on the output between strobes.
      if (state_reg == EMIT) uart_data_reg <= char_sel;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tmo_next   = tmo_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = EMIT;
          idx_next   = '0;
        end
      end
      EMIT: begin
        state_next = WAIT_HI;
        tmo_next   = '0;
      end
      WAIT_HI: begin
        // A transmitter that never raises busy must not stall the line forever.
        if (i_uart_busy || tmo_reg == TMO_W'(BUSY_TIMEOUT - 1)) state_next = WAIT_LO;
        else tmo_next = tmo_reg + TMO_W'(1);
      end
      WAIT_LO: begin
        if (!i_uart_busy) begin
          if (idx_reg < IDX_W'(L - 1)) begin
            state_next = EMIT;
            idx_next   = idx_reg + IDX_W'(1);
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        idx_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready     = (state_reg == IDLE);
    o_busy      = (state_reg != IDLE);
    o_uart_dv   = (state_reg == EMIT);
    o_uart_data = (state_reg == EMIT) ? char_sel : uart_data_reg;
    o_overflow  = overflow_reg;
  end

endmodule

// File: tb/tb_uart_hex_line_formatter.sv
// Scoreboard bench: two formatter instances (full line format, and data+LF only)
// driven against a simple busy-flag transmitter model.
module tb_uart_hex_line_formatter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] data_a, data_b;
  logic [4:0]  addr_a, addr_b;
  logic        dv_a, dv_b;
  logic        ready_a, uart_dv_a, busy_a, ovf_a, ubusy_a;
  logic        ready_b, uart_dv_b, busy_b, ovf_b, ubusy_b;
  logic [7:0]  udata_a, udata_b;

  int cnt_a = 0, cnt_b = 0, cyc = 0;
  bit busy_en_a = 1'b1;
  int tests = 0, fails = 0;

  logic [7:0] exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  int         obs_ta[$];

  always #5 clk = ~clk;

  uart_hex_line_formatter #(.DATA_WIDTH(16), .ADDR_EN(1), .CRLF(1), .BUSY_TIMEOUT(4)) dut_a (
    .clk(clk), .i_reset(i_reset), .i_data(data_a), .i_addr(addr_a), .i_dv(dv_a),
    .o_ready(ready_a), .o_uart_data(udata_a), .o_uart_dv(uart_dv_a),
    .i_uart_busy(ubusy_a), .o_busy(busy_a), .o_overflow(ovf_a)
  );

  uart_hex_line_formatter #(.DATA_WIDTH(16), .ADDR_EN(0), .CRLF(0), .BUSY_TIMEOUT(4)) dut_b (
    .clk(clk), .i_reset(i_reset), .i_data(data_b), .i_addr(addr_b), .i_dv(dv_b),
    .o_ready(ready_b), .o_uart_data(udata_b), .o_uart_dv(uart_dv_b),
    .i_uart_busy(ubusy_b), .o_busy(busy_b), .o_overflow(ovf_b)
  );

  // Transmitter model: busy for 10 cycles starting the cycle after each strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!busy_en_a)     cnt_a <= 0;
    else if (uart_dv_a) cnt_a <= 10;
    else if (cnt_a > 0) cnt_a <= cnt_a - 1;
    if (uart_dv_b)      cnt_b <= 10;
    else if (cnt_b > 0) cnt_b <= cnt_b - 1;
  end
  assign ubusy_a = (cnt_a != 0);
  assign ubusy_b = (cnt_b != 0);

  always @(negedge clk) begin
    if (uart_dv_a) begin
      obs_a.push_back(udata_a);
      obs_ta.push_back(cyc);
    end
    if (uart_dv_b) obs_b.push_back(udata_b);
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic push_line_a(input logic [15:0] d, input logic [4:0] a);
    logic [7:0] a8;
    a8 = {3'b000, a};
    exp_a.push_back(hexc(a8[7:4]));
    exp_a.push_back(hexc(a8[3:0]));
    exp_a.push_back(8'h3A);
    for (int k = 3; k >= 0; k--) exp_a.push_back(hexc(d[k*4 +: 4]));
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
  endtask

  task automatic send_a(input logic [15:0] d, input logic [4:0] a);
    data_a = d; addr_a = a; dv_a = 1'b1;
    push_line_a(d, a);
    @(posedge clk); #1;
    dv_a = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (ready_a !== 1'b1)    begin fails++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
    tests++; if (uart_dv_a !== 1'b0)  begin fails++; $display("FAIL reset_dv: got %b expected 0", uart_dv_a); end
    tests++; if (udata_a !== 8'h00)   begin fails++; $display("FAIL reset_data: got %h expected 00", udata_a); end
    tests++; if (busy_a !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    tests++; if (ovf_a !== 1'b0)      begin fails++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
    tests++; if (ready_b !== 1'b1)    begin fails++; $display("FAIL reset_ready_b: got %b expected 1", ready_b); end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    bit ok, busy_drop;
    int n;
    logic [7:0] e, o;
    obs_a.delete(); obs_ta.delete();
    send_a(16'h796D, 5'h01);
    tests++; if (uart_dv_a !== 1'b1) begin fails++; $display("FAIL basic_latency: dv got %b expected 1", uart_dv_a); end
    tests++; if (ready_a !== 1'b0)   begin fails++; $display("FAIL basic_ready_low: got %b expected 0", ready_a); end
    ok = 0; busy_drop = 0;
    for (int c = 0; c < 400; c++) begin
      if (busy_a !== 1'b1) busy_drop = 1;
      @(posedge clk); #1;
      if (ready_a) begin ok = 1; break; end
    end
    tests++; if (!ok)      begin fails++; $display("FAIL basic_timeout: o_ready got 0 expected 1"); end
    tests++; if (busy_drop) begin fails++; $display("FAIL basic_busy: o_busy got 0 mid-line expected 1"); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL basic_busy_end: got %b expected 0", busy_a); end
    n = exp_a.size();
    for (int i = 0; i < n; i++) begin
      e = exp_a.pop_front();
      tests++;
      if (obs_a.size() == 0) begin fails++; $display("FAIL basic_byte%0d: got none expected %h", i, e); end
      else begin
        o = obs_a.pop_front();
        if (o !== e) begin fails++; $display("FAIL basic_byte%0d: got %h expected %h", i, o, e); end
      end
    end
    tests++; if (obs_a.size() != 0) begin fails++; $display("FAIL basic_extra: got %0d extra bytes expected 0", obs_a.size()); end
    $display("[TB] line 01:796D checked");
  endtask

  task automatic test_no_addr_no_crlf();
    bit ok;
    logic [7:0] e, o;
    obs_b.delete();
    data_b = 16'hFFFF; addr_b = 5'h1F; dv_b = 1'b1;
    for (int k = 0; k < 4; k++) exp_b.push_back(8'h46);
    exp_b.push_back(8'h0A);
    @(posedge clk); #1;
    dv_b = 1'b0;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (ready_b) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL noaddr_timeout: o_ready got 0 expected 1"); end
    tests++; if (obs_b.size() != 5) begin fails++; $display("FAIL noaddr_len: got %0d bytes expected 5", obs_b.size()); end
    for (int i = 0; i < 5; i++) begin
      e = exp_b.pop_front();
      tests++;
      if (obs_b.size() == 0) begin fails++; $display("FAIL noaddr_byte%0d: got none expected %h", i, e); end
      else begin
        o = obs_b.pop_front();
        if (o !== e) begin fails++; $display("FAIL noaddr_byte%0d: got %h expected %h", i, o, e); end
      end
    end
    obs_b.delete();
    $display("[TB] line FFFF (no addr, LF only) checked");
  endtask

  task automatic test_busy_stuck_low();
    bit ok;
    int n;
    logic [7:0] e, o;
    busy_en_a = 1'b0;
    @(posedge clk); #1;
    obs_a.delete(); obs_ta.delete();
    send_a(16'hA5C3, 5'h12);
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (ready_a) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL nobusy_timeout: o_ready got 0 expected 1"); end
    tests++; if (obs_ta.size() != 9) begin fails++; $display("FAIL nobusy_count: got %0d strobes expected 9", obs_ta.size()); end
    for (int i = 1; i < obs_ta.size(); i++) begin
      tests++;
      if (obs_ta[i] - obs_ta[i-1] != 6) begin
        fails++; $display("FAIL nobusy_spacing%0d: got %0d cycles expected 6", i, obs_ta[i] - obs_ta[i-1]);
      end
    end
    n = exp_a.size();
    for (int i = 0; i < n; i++) begin
      e = exp_a.pop_front();
      tests++;
      if (obs_a.size() == 0) begin fails++; $display("FAIL nobusy_byte%0d: got none expected %h", i, e); end
      else begin
        o = obs_a.pop_front();
        if (o !== e) begin fails++; $display("FAIL nobusy_byte%0d: got %h expected %h", i, o, e); end
      end
    end
    busy_en_a = 1'b1;
    $display("[TB] line 12:A5C3 with busy stuck low checked");
  endtask

  task automatic test_overflow();
    bit ok;
    int n;
    logic [7:0] e, o;
    obs_a.delete(); obs_ta.delete();
    send_a(16'h796D, 5'h01);
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (obs_a.size() >= 3) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL ovf_wait3: third byte got none expected strobe"); end
    @(posedge clk); #1;
    data_a = 16'h1234; addr_a = 5'h02; dv_a = 1'b1;
    @(posedge clk); #1;
    dv_a = 1'b0;
    tests++; if (ovf_a !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", ovf_a); end
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (ready_a) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout: o_ready got 0 expected 1"); end
    repeat (40) @(posedge clk);
    #1;
    tests++; if (obs_a.size() != 9) begin fails++; $display("FAIL ovf_len: got %0d bytes expected 9", obs_a.size()); end
    tests++; if (ovf_a !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", ovf_a); end
    n = exp_a.size();
    for (int i = 0; i < n; i++) begin
      e = exp_a.pop_front();
      tests++;
      if (obs_a.size() == 0) begin fails++; $display("FAIL ovf_byte%0d: got none expected %h", i, e); end
      else begin
        o = obs_a.pop_front();
        if (o !== e) begin fails++; $display("FAIL ovf_byte%0d: got %h expected %h", i, o, e); end
      end
    end
    obs_a.delete();
    $display("[TB] overflow during line 01:796D checked");
  endtask

  task automatic test_reset_midline();
    bit ok;
    int n;
    logic [7:0] e, o;
    obs_a.delete(); obs_ta.delete();
    send_a(16'h796D, 5'h01);
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (obs_a.size() >= 4) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_wait4: fourth byte got none expected strobe"); end
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (uart_dv_a !== 1'b0) begin fails++; $display("FAIL rstmid_dv: got %b expected 0", uart_dv_a); end
    tests++; if (ready_a !== 1'b1)   begin fails++; $display("FAIL rstmid_ready: got %b expected 1", ready_a); end
    tests++; if (ovf_a !== 1'b0)     begin fails++; $display("FAIL rstmid_ovf: got %b expected 0", ovf_a); end
    @(posedge clk); #1;
    i_reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    tests++; if (obs_a.size() != 4) begin fails++; $display("FAIL rstmid_len: got %0d bytes expected 4", obs_a.size()); end
    for (int i = 0; i < 4; i++) begin
      e = exp_a.pop_front();
      tests++;
      if (obs_a.size() == 0) begin fails++; $display("FAIL rstmid_byte%0d: got none expected %h", i, e); end
      else begin
        o = obs_a.pop_front();
        if (o !== e) begin fails++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, o, e); end
      end
    end
    exp_a.delete(); obs_a.delete(); obs_ta.delete();
    send_a(16'h0000, 5'h00);
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (ready_a) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_timeout: o_ready got 0 expected 1"); end
    n = exp_a.size();
    for (int i = 0; i < n; i++) begin
      e = exp_a.pop_front();
      tests++;
      if (obs_a.size() == 0) begin fails++; $display("FAIL rstmid_new%0d: got none expected %h", i, e); end
      else begin
        o = obs_a.pop_front();
        if (o !== e) begin fails++; $display("FAIL rstmid_new%0d: got %h expected %h", i, o, e); end
      end
    end
    $display("[TB] reset mid-line then line 00:0000 checked");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [7:0] e, o;
    obs_a.delete(); obs_ta.delete();
    send_a(16'hBEEF, 5'h0A);
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (ready_a) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout1: o_ready got 0 expected 1"); end
    send_a(16'h0123, 5'h1F);
    tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL b2b_accept: o_ready got %b expected 0", ready_a); end
    tests++; if (ovf_a !== 1'b0)   begin fails++; $display("FAIL b2b_ovf: got %b expected 0", ovf_a); end
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (ready_a) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout2: o_ready got 0 expected 1"); end
    tests++; if (obs_a.size() != 18) begin fails++; $display("FAIL b2b_len: got %0d bytes expected 18", obs_a.size()); end
    n = exp_a.size();
    for (int i = 0; i < n; i++) begin
      e = exp_a.pop_front();
      tests++;
      if (obs_a.size() == 0) begin fails++; $display("FAIL b2b_byte%0d: got none expected %h", i, e); end
      else begin
        o = obs_a.pop_front();
        if (o !== e) begin fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, o, e); end
      end
    end
    $display("[TB] back-to-back lines 0A:BEEF and 1F:0123 checked");
  endtask

  initial begin
    i_reset = 1'b1;
    data_a = '0; addr_a = '0; dv_a = 1'b0;
    data_b = '0; addr_b = '0; dv_b = 1'b0;
    test_reset();
    test_basic();
    test_no_addr_no_crlf();
    test_busy_stuck_low();
    test_overflow();
    test_reset_midline();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
